// File: rtl/pc_controller.sv
// Fetch/issue sequencer: reads 1-3 instruction bytes through the PC, then holds the bundle until accepted.
// One memory handshake per byte; ISSUE stalls on instr_ready; a branch aborts the fetch/issue and redirects the PC.
module pc_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] next_pc,
    output logic             clk_enable,
    output logic             mode,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_opcode,
    output logic [WIDTH-1:0] instr_op1,
    output logic [WIDTH-1:0] instr_op2,
    output logic [1:0]       instr_len,
    output logic             halted
);
    typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE, HALT} state_t;

    state_t     state;
    logic       fetching;
    logic       redirect;
    logic       take_ack;
    logic       is_halt_op;
    logic [1:0] op_len;

    assign fetching   = (state == FETCH_OP) || (state == FETCH_B1) || (state == FETCH_B2);
    assign redirect   = branch_valid && (fetching || state == ISSUE);
    assign take_ack   = fetching && mem_ack && !branch_valid;
    assign mem_req    = fetching;
    assign mem_addr   = pc;
    assign is_halt_op = &mem_rdata;
    assign op_len     = mem_rdata[WIDTH-1] ? 2'd3 : (mem_rdata[WIDTH-2] ? 2'd2 : 2'd1);

    // Redirect wins over an increment, so at most one PC update per cycle.
    always_comb begin
        clk_enable = 1'b0;
        mode       = 1'b0;
        next_pc    = '0;
        if (redirect) begin
            clk_enable = 1'b1;
            mode       = 1'b1;
            next_pc    = branch_target;
        end else if (take_ack) begin
            clk_enable = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            instr_valid  <= 1'b0;
            halted       <= 1'b0;
            instr_opcode <= '0;
            instr_op1    <= '0;
            instr_op2    <= '0;
            instr_len    <= 2'd0;
        end else if (redirect) begin
            state        <= FETCH_OP;
            instr_valid  <= 1'b0;
            instr_opcode <= '0;
            instr_op1    <= '0;
            instr_op2    <= '0;
            instr_len    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= FETCH_OP;
                end
                FETCH_OP: begin
                    if (mem_ack) begin
                        instr_opcode <= mem_rdata;
                        instr_op1    <= '0;
                        instr_op2    <= '0;
                        if (is_halt_op) begin
                            instr_len <= 2'd1;
                            halted    <= 1'b1;
                            state     <= HALT;
                        end else begin
                            instr_len <= op_len;
                            if (op_len == 2'd1) begin
                                instr_valid <= 1'b1;
                                state       <= ISSUE;
                            end else begin
                                state <= FETCH_B1;
                            end
                        end
                    end
                end
                FETCH_B1: begin
                    if (mem_ack) begin
                        instr_op1 <= mem_rdata;
                        if (instr_len == 2'd2) begin
                            instr_valid <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            state <= FETCH_B2;
                        end
                    end
                end
                FETCH_B2: begin
                    if (mem_ack) begin
                        instr_op2   <= mem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= run ? FETCH_OP : IDLE;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_controller.sv
// Directed bench for pc_controller with a behavioural program counter in the loop.
module tb_pc_controller;
    logic       clk = 1'b0;
    logic       reset, run, mem_ack, branch_valid, instr_ready;
    logic [7:0] pc, next_pc, mem_addr, mem_rdata, branch_target;
    logic [7:0] instr_opcode, instr_op1, instr_op2;
    logic [1:0] instr_len;
    logic       clk_enable, mode, mem_req, instr_valid, halted;
    logic       force_pc;
    logic [7:0] force_val;
    int         passed = 0;
    int         total = 0;

    pc_controller #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .run(run), .pc(pc), .next_pc(next_pc),
        .clk_enable(clk_enable), .mode(mode), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .branch_valid(branch_valid),
        .branch_target(branch_target), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_op1(instr_op1), .instr_op2(instr_op2),
        .instr_len(instr_len), .halted(halted)
    );

    always #5 clk = ~clk;

    // External program counter: increments or loads on clk_enable; force_pc presets it.
    always @(posedge clk) begin
        if (force_pc)        pc <= force_val;
        else if (clk_enable) pc <= mode ? next_pc : pc + 8'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        branch_valid = 1'b0; branch_target = 8'h00; instr_ready = 1'b0;
        force_pc = 1'b1; force_val = 8'h10; pc = 8'h00;
        step(); step();
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_len", 32'(instr_len), 0);
        chk("rst_opcode", 32'(instr_opcode), 0);
        chk("rst_clk_en", 32'(clk_enable), 0);

        force_pc = 1'b0; reset = 1'b1;
        step();
        chk("idle_hold_req", 32'(mem_req), 0);

        // 1-byte instruction, ack arrives after two wait cycles
        run = 1'b1;
        step();
        #1;
        chk("fop_req", 32'(mem_req), 1);
        chk("fop_addr", 32'(mem_addr), 32'h10);
        chk("fop_wait_noen", 32'(clk_enable), 0);
        step(); step();
        chk("fop_still_req", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 8'h05;
        #1;
        chk("ack_en", 32'(clk_enable), 1);
        chk("ack_mode", 32'(mode), 0);
        step();
        mem_ack = 1'b0;
        chk("i1_valid", 32'(instr_valid), 1);
        chk("i1_opcode", 32'(instr_opcode), 32'h05);
        chk("i1_len", 32'(instr_len), 1);
        chk("i1_op1", 32'(instr_op1), 0);
        chk("i1_op2", 32'(instr_op2), 0);
        chk("i1_pc", 32'(pc), 32'h11);
        chk("i1_no_req", 32'(mem_req), 0);
        instr_ready = 1'b1;
        #1;
        chk("issue_noen", 32'(clk_enable), 0);
        step();
        instr_ready = 1'b0;
        chk("i1_accepted", 32'(instr_valid), 0);
        chk("i1_back_fetch", 32'(mem_req), 1);
        chk("i1_pc_once", 32'(pc), 32'h11);

        // 3-byte instruction from 0x10, held across three stalled cycles
        force_pc = 1'b1; force_val = 8'h10;
        step();
        force_pc = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h80; step();
        mem_rdata = 8'h12; step();
        mem_rdata = 8'h34; step();
        mem_ack = 1'b0;
        chk("i3_pc", 32'(pc), 32'h13);
        for (int i = 0; i < 3; i++) begin
            chk("i3_valid", 32'(instr_valid), 1);
            chk("i3_bundle", {8'h00, instr_opcode, instr_op1, instr_op2}, 32'h00801234);
            chk("i3_len", 32'(instr_len), 3);
            chk("i3_pc_hold", 32'(pc), 32'h13);
            step();
        end
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk("i3_accepted", 32'(instr_valid), 0);

        // Branch in FETCH_B1 colliding with mem_ack
        mem_ack = 1'b1; mem_rdata = 8'h40; step();
        chk("br_pre_pc", 32'(pc), 32'h14);
        mem_rdata = 8'h99; branch_valid = 1'b1; branch_target = 8'hA5;
        #1;
        chk("br_en", 32'(clk_enable), 1);
        chk("br_mode", 32'(mode), 1);
        chk("br_next", 32'(next_pc), 32'hA5);
        step();
        branch_valid = 1'b0; mem_ack = 1'b0;
        chk("br_pc", 32'(pc), 32'hA5);
        chk("br_fetch_op", 32'(mem_addr), 32'hA5);
        chk("br_req", 32'(mem_req), 1);
        chk("br_no_valid", 32'(instr_valid), 0);
        step();
        chk("br_no_valid2", 32'(instr_valid), 0);

        // 2-byte fetch wrapping from 0xFF to 0x00
        force_pc = 1'b1; force_val = 8'hFF;
        step();
        force_pc = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h41; step();
        mem_ack = 1'b0;
        #1;
        chk("wrap_addr", 32'(mem_addr), 32'h00);
        chk("wrap_req", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 8'h22; step();
        mem_ack = 1'b0;
        chk("wrap_bundle", {16'h0, instr_opcode, instr_op1}, 32'h4122);
        chk("wrap_len", 32'(instr_len), 2);
        chk("wrap_pc", 32'(pc), 32'h01);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;

        // Reset asserted in FETCH_B2 with an ack pending
        mem_ack = 1'b1; mem_rdata = 8'h81; step();
        mem_rdata = 8'h01; step();
        chk("b2_pc", 32'(pc), 32'h03);
        mem_rdata = 8'h55;
        #2 reset = 1'b0;
        #1;
        chk("rst_b2_req", 32'(mem_req), 0);
        chk("rst_b2_en", 32'(clk_enable), 0);
        chk("rst_b2_valid", 32'(instr_valid), 0);
        chk("rst_b2_len", 32'(instr_len), 0);
        chk("rst_b2_op", {16'h0, instr_opcode, instr_op1}, 0);
        step();
        chk("rst_b2_pc", 32'(pc), 32'h03);
        mem_ack = 1'b0; reset = 1'b1;

        // HALT opcode
        step();
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        #1;
        chk("halt_ack_en", 32'(clk_enable), 1);
        step();
        mem_ack = 1'b0;
        chk("halt_flag", 32'(halted), 1);
        chk("halt_req", 32'(mem_req), 0);
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_pc", 32'(pc), 32'h04);
        branch_valid = 1'b1; branch_target = 8'h33; mem_ack = 1'b1;
        #1;
        chk("halt_br_noen", 32'(clk_enable), 0);
        step();
        branch_valid = 1'b0; mem_ack = 1'b0; run = 1'b0;
        step();
        run = 1'b1;
        step();
        chk("halt_stuck", 32'(halted), 1);
        chk("halt_pc_hold", 32'(pc), 32'h04);
        reset = 1'b0;
        #1;
        chk("halt_cleared", 32'(halted), 0);
        reset = 1'b1;
        step();
        chk("post_halt", 32'(halted), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc_controller.md
PC_CONTROLLER -- requirements
Module: pc_controller

Interface
REQ-001 Parameter WIDTH, default 8, sets the width of the PC, memory address, branch target and memory data.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level start; leaving IDLE requires run=1.
REQ-005 pc  input  WIDTH  current value from program_counter.
REQ-006 next_pc  output  WIDTH  load value to program_counter.
REQ-007 clk_enable  output  1  program_counter update strobe.
REQ-008 mode  output  1  program_counter op: 0=increment, 1=write.
REQ-009 mem_req  output  1  instruction-byte read request.
REQ-010 mem_addr  output  WIDTH  read address; always equals pc.
REQ-011 mem_ack  input  1  read complete, mem_rdata valid this cycle.
REQ-012 mem_rdata  input  WIDTH  fetched byte.
REQ-013 branch_valid  input  1  one-cycle redirect request from execute.
REQ-014 branch_target  input  WIDTH  redirect address.
REQ-015 instr_valid  output  1  decoded instruction bundle valid.
REQ-016 instr_ready  input  1  consumer accepts the bundle.
REQ-017 instr_opcode, instr_op1, instr_op2  output  WIDTH each  bundle bytes; unused operands are 0.
REQ-018 instr_len  output  2  bundle length: 1..3.
REQ-019 halted  output  1  HALT state indicator.

Function
REQ-020 The FSM SHALL have the states IDLE, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE and HALT.
REQ-021 clk_enable, mode and next_pc SHALL be combinational; default values are clk_enable=0, mode=0, next_pc=0.
REQ-022 IDLE SHALL transition to FETCH_OP when run=1; otherwise it holds, with mem_req=0.
REQ-023 In FETCH_* states, mem_req SHALL be 1 and held until mem_ack; there is no fixed latency.
REQ-024 On mem_ack in any FETCH_* state:
- clk_enable=1 and mode=0 in that same cycle, so the PC increments on that edge;
- the byte is captured into the matching bundle field.
REQ-025 Length is decoded from the opcode:
- 8'hFF = HALT (length 1);
- otherwise opcode[7:6]: 00 gives 1, 01 gives 2, 1x gives 3.
REQ-026 Transitions:
- FETCH_OP goes to ISSUE (length 1), FETCH_B1 (length 2 or 3), or HALT (8'hFF).
- FETCH_B1 goes to ISSUE (length 2) or FETCH_B2 (length 3).
- FETCH_B2 goes to ISSUE.
REQ-027 In ISSUE, instr_valid=1 and the bundle SHALL be held stable until instr_ready=1; the state then goes to FETCH_OP the next cycle (or IDLE if run=0), and no PC update occurs in ISSUE.
REQ-028 branch_valid in FETCH_* or ISSUE SHALL take priority over mem_ack:
- that cycle: clk_enable=1, mode=1, next_pc=branch_target;
- the partial bundle is discarded and the state goes to FETCH_OP.
REQ-029 If instr_valid and instr_ready are both high in the same cycle as branch_valid, the bundle SHALL count as accepted and the redirect is still taken.
REQ-030 branch_valid SHALL be ignored in IDLE and HALT.
REQ-031 mem_ack SHALL be ignored outside FETCH_* states.
REQ-032 HALT SHALL be exited only by reset; in HALT, halted=1, mem_req=0 and clk_enable=0.
REQ-033 PC wrap-around (all-ones to 0) SHALL need no special handling; fetch continues at 0.
REQ-034 At most one PC update SHALL occur per cycle.

Reset
REQ-035 While reset=0, the controller SHALL be in IDLE with all registered outputs 0: instr_valid, halted, the bundle and instr_len.
REQ-036 Reset asserted mid-fetch or mid-issue SHALL abort the operation immediately with no PC update; mem_req drops asynchronously.

Verification
REQ-037 Start/1-byte instruction: pc=0x10, run=1, rdata=0x05 with ack after 2 cycles -> exactly one increment; instr_valid with opcode=0x05, len=1, op1=op2=0.
REQ-038 3-byte instruction: bytes 0x80, 0x12, 0x34 -> three increments (0x10 to 0x13); bundle 80/12/34, len=3, held across 3 cycles of instr_ready=0.
REQ-039 Branch mid-fetch: in FETCH_B1, branch_valid=1 with target=0xA5 and mem_ack=1 in the same cycle -> mode=1, next_pc=0xA5, no increment, back to FETCH_OP, no instr_valid for the aborted instruction.
REQ-040 Halt: rdata=0xFF -> halted=1 and mem_req=0; later branch_valid and run pulses cause no clk_enable; cleared only by reset=0.
REQ-041 Wrap/reset: pc=0xFF, 2-byte fetch -> second byte is read at mem_addr=0x00; reset=0 asserted during FETCH_B2 -> IDLE and all outputs 0 immediately.
